// File: rtl/core_seq_pkg.sv
// Shared definitions for the core sequencer: instruction kinds, control-word
// field positions, FSM state encoding and the core input-mux encodings.
package core_seq_pkg;

  // Instruction kind, bits [31:30] of the control word
  localparam logic [1:0] KIND_EXEC = 2'b00;
  localparam logic [1:0] KIND_LOOP = 2'b01;
  localparam logic [1:0] KIND_BRNZ = 2'b10;
  localparam logic [1:0] KIND_HALT = 2'b11;

  // Field bit positions
  localparam int unsigned KIND_LSB   = 30;
  localparam int unsigned OPC_LSB    = 0;
  localparam int unsigned INSEL_LSB  = 4;
  localparam int unsigned OUTSEL_BIT = 6;
  localparam int unsigned SAVE_BIT   = 7;
  localparam int unsigned OEN_BIT    = 8;
  localparam int unsigned WE_BIT     = 9;
  localparam int unsigned RADDR_LSB  = 10;
  localparam int unsigned WADDR_LSB  = 18;
  localparam int unsigned LOOP_LSB   = 0;

  // Core input-mux select encodings
  localparam logic [1:0] INSEL_ALU     = 2'd0;
  localparam logic [1:0] INSEL_CORE_ID = 2'd1;
  localparam logic [1:0] INSEL_RAM     = 2'd2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_READ,
    ST_ISSUE,
    ST_DRAIN,
    ST_DONE
  } state_t;

  // Latched EXEC control fields
  typedef struct packed {
    logic [3:0] opcode;
    logic [1:0] insel;
    logic       outsel;
    logic       save;
    logic       oen;
    logic       we;
    logic [7:0] waddr;
  } exec_t;

endpackage

// File: rtl/core_seq_wb_pipe.sv
// Write-back delay line: carries {we, waddr} DEPTH cycles so the scratch-RAM
// write lines up with the clocked ALU result.
//   clk, rst_n        : clock, asynchronous active-low reset
//   flush             : synchronous clear of all pending writes
//   push_we/push_waddr: write request entering the line
//   we/waddr          : write request leaving the line
//   pending           : any stage holds a write enable
module core_seq_wb_pipe #(
  parameter int unsigned DEPTH = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       flush,
  input  logic       push_we,
  input  logic [7:0] push_waddr,
  output logic       we,
  output logic [7:0] waddr,
  output logic       pending
);

  logic [DEPTH-1:0] we_q;
  logic [7:0]       waddr_q [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) waddr_q[i] <= '0;
    end else if (flush) begin
      // Only the enables matter for suppressing writes; addresses are don't-care.
      we_q <= '0;
    end else begin
      we_q[0]    <= push_we;
      waddr_q[0] <= push_waddr;
      for (int unsigned i = 1; i < DEPTH; i++) begin
        we_q[i]    <= we_q[i-1];
        waddr_q[i] <= waddr_q[i-1];
      end
    end
  end

  assign we      = we_q[DEPTH-1];
  assign waddr   = waddr_q[DEPTH-1];
  assign pending = |we_q;

endmodule

// File: rtl/core_sequencer.sv
// Microcoded sequencer broadcasting datapath control to the core array.
// Fetches 32-bit control words from a synchronous ROM, supports one level of
// hardware loop and delays RAM write-back by ALU_LATENCY cycles.
//   clk_i, rst_ni          : clock, asynchronous active-low reset
//   start_i, start_pc_i    : start pulse and entry address (sampled in IDLE)
//   abort_i                : abandon program, flush pending writes
//   busy_o, done_o         : status / one-cycle completion pulse
//   prog_addr_o/prog_data_i: program ROM port (1-cycle read latency)
//   alu_opcode_o .. output_enable_o : core control, valid in ISSUE only
//   ram_raddr_o, ram_waddr_o, ram_we_o : scratch RAM control
module core_sequencer
  import core_seq_pkg::*;
#(
  parameter int unsigned PROG_AW     = 8,
  parameter int unsigned ALU_LATENCY = 2,
  parameter logic [3:0]  NOP_OPCODE  = 4'h0
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               start_i,
  input  logic [PROG_AW-1:0] start_pc_i,
  input  logic               abort_i,
  output logic               busy_o,
  output logic               done_o,
  output logic [PROG_AW-1:0] prog_addr_o,
  input  logic [31:0]        prog_data_i,
  output logic [3:0]         alu_opcode_o,
  output logic [1:0]         input_select_o,
  output logic               output_select_o,
  output logic               save_selection_o,
  output logic               output_enable_o,
  output logic [7:0]         ram_raddr_o,
  output logic [7:0]         ram_waddr_o,
  output logic               ram_we_o
);

  state_t             state_q, state_d;
  logic [PROG_AW-1:0] pc_q, pc_d;
  logic [15:0]        loop_q, loop_d;
  exec_t              ex_q;
  logic               wb_pending;
  logic               flush;
  logic               issue_we;
  logic [1:0]         kind;
  logic               unused_rom_bits;

  assign kind            = prog_data_i[KIND_LSB +: 2];
  assign unused_rom_bits = ^prog_data_i[29:26];
  assign flush           = abort_i && (state_q != ST_IDLE);
  assign issue_we        = (state_q == ST_ISSUE) && ex_q.we;
  assign prog_addr_o     = pc_q;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    loop_d  = loop_q;
    if (flush) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            state_d = ST_FETCH;
            pc_d    = start_pc_i;
          end
        end
        ST_FETCH:  state_d = ST_DECODE;
        ST_DECODE: begin
          unique case (kind)
            KIND_EXEC: state_d = ST_READ;
            KIND_LOOP: begin
              loop_d  = prog_data_i[LOOP_LSB +: 16];
              pc_d    = pc_q + PROG_AW'(1);
              state_d = ST_FETCH;
            end
            KIND_BRNZ: begin
              if (loop_q != '0) begin
                loop_d = loop_q - 16'd1;
                pc_d   = prog_data_i[PROG_AW-1:0];
              end else begin
                pc_d = pc_q + PROG_AW'(1);
              end
              state_d = ST_FETCH;
            end
            default: state_d = ST_DRAIN;
          endcase
        end
        ST_READ:  state_d = ST_ISSUE;
        ST_ISSUE: begin
          pc_d    = pc_q + PROG_AW'(1);
          state_d = ST_FETCH;
        end
        ST_DRAIN: if (!wb_pending) state_d = ST_DONE;
        ST_DONE:  state_d = ST_IDLE;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      pc_q    <= '0;
      loop_q  <= '0;
      ex_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      loop_q  <= loop_d;
      if (state_d == ST_READ) begin
        ex_q <= '{opcode: prog_data_i[OPC_LSB +: 4],
                  insel:  prog_data_i[INSEL_LSB +: 2],
                  outsel: prog_data_i[OUTSEL_BIT],
                  save:   prog_data_i[SAVE_BIT],
                  oen:    prog_data_i[OEN_BIT],
                  we:     prog_data_i[WE_BIT],
                  waddr:  prog_data_i[WADDR_LSB +: 8]};
      end
    end
  end

  // Outputs are registered from the next state so they line up with the
  // state they belong to.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      busy_o           <= 1'b0;
      done_o           <= 1'b0;
      alu_opcode_o     <= NOP_OPCODE;
      input_select_o   <= '0;
      output_select_o  <= 1'b0;
      save_selection_o <= 1'b0;
      output_enable_o  <= 1'b0;
      ram_raddr_o      <= '0;
    end else begin
      busy_o <= (state_d != ST_IDLE);
      done_o <= (state_d == ST_DONE);
      if (state_d == ST_READ) ram_raddr_o <= prog_data_i[RADDR_LSB +: 8];
      if (state_d == ST_ISSUE) begin
        alu_opcode_o     <= ex_q.opcode;
        input_select_o   <= ex_q.insel;
        output_select_o  <= ex_q.outsel;
        save_selection_o <= ex_q.save;
        output_enable_o  <= ex_q.oen;
      end else begin
        alu_opcode_o     <= NOP_OPCODE;
        input_select_o   <= '0;
        output_select_o  <= 1'b0;
        save_selection_o <= 1'b0;
        output_enable_o  <= 1'b0;
      end
    end
  end

  core_seq_wb_pipe #(
    .DEPTH(ALU_LATENCY)
  ) u_wb_pipe (
    .clk       (clk_i),
    .rst_n     (rst_ni),
    .flush     (flush),
    .push_we   (issue_we),
    .push_waddr(ex_q.waddr),
    .we        (ram_we_o),
    .waddr     (ram_waddr_o),
    .pending   (wb_pending)
  );

endmodule
